// File: rtl/gsu_alu_pkg.sv
// Shared definitions for the registered GSU ALU.
//  - Opcode encodings (4-bit) as issued by the instruction decoder.
//  - flag_we masks, bit order {ov, cy, s, zf}.
//  - FSM state type for the multiply sequencer.
//  - is_mul(): true for the multi-cycle multiply group.
package gsu_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SBC   = 4'd3;
  localparam logic [3:0] OP_CMP   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_BIC   = 4'd8;
  localparam logic [3:0] OP_ROR   = 4'd9;
  localparam logic [3:0] OP_LSR   = 4'd10;
  localparam logic [3:0] OP_SWAP  = 4'd11;
  localparam logic [3:0] OP_MULT  = 4'd12;
  localparam logic [3:0] OP_UMULT = 4'd13;
  localparam logic [3:0] OP_FMULT = 4'd14;
  localparam logic [3:0] OP_LMULT = 4'd15;

  localparam logic [3:0] FWE_ARITH = 4'b1111;
  localparam logic [3:0] FWE_LOGIC = 4'b0011;
  localparam logic [3:0] FWE_SHIFT = 4'b0111;
  localparam logic [3:0] FWE_MUL   = 4'b0011;
  localparam logic [3:0] FWE_LMUL  = 4'b0111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Multiply group occupies codes 12..15.
  function automatic logic is_mul(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/gsu_alu_mul_seq.sv
// Sequential radix-2 shift-add multiplier.
//  clk, rst     clock, synchronous active-high reset (aborts a run)
//  start_i      load operands and perform the first iteration
//  full_i       0: WIDTH/2 x WIDTH/2 (low halves), 1: WIDTH x WIDTH
//  signed_i     two's-complement operands
//  a_i, b_i     multiplicand / multiplier
//  done_o       one-cycle pulse, registered on the edge of the final iteration
//  prod_o       2*WIDTH product, valid while done_o=1
module gsu_alu_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 full_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               sgn_q, sgn_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] a_ext;
  logic [WIDTH-1:0]   b_ext;
  logic [2*WIDTH-1:0] pp;
  logic               last;

  always_comb begin
    if (full_i) begin
      a_ext = {{WIDTH{signed_i & a_i[WIDTH-1]}}, a_i};
      b_ext = b_i;
    end else begin
      a_ext = {{(WIDTH + HALF){signed_i & a_i[HALF-1]}}, a_i[HALF-1:0]};
      b_ext = {{HALF{1'b0}}, b_i[HALF-1:0]};
    end
  end

  // Iteration 0 is folded into the load cycle so the run takes exactly
  // len edges (load + len-1 more); the counter therefore starts at len-2.
  // The multiplier MSB carries negative weight when signed, so its partial
  // product is subtracted instead of added on the final iteration.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    active_d = active_q;
    done_d   = 1'b0;
    pp       = mplier_q[0] ? mcand_q : '0;
    last     = (cnt_q == '0);
    if (start_i) begin
      acc_d    = b_ext[0] ? a_ext : '0;
      mcand_d  = a_ext << 1;
      mplier_d = b_ext >> 1;
      cnt_d    = full_i ? CNT_W'(WIDTH - 2) : CNT_W'(HALF - 2);
      sgn_d    = signed_i;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = (sgn_q && last) ? (acc_q - pp) : (acc_q + pp);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (last) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/gsu_alu_seq.sv
// Registered GSU ALU with multi-cycle multiply under a start/done handshake.
//  clk, rst          clock, synchronous active-high reset
//  start, op         issue request and opcode (ignored while busy)
//  x, y, imm         operands; y_src_sel picks Y = y or zero-extended imm
//  cy_in             stored carry for ADC/SBC/ROR
//  busy              multiply in progress
//  done              one-cycle result strobe; z/z_hi/flags valid only then
//  z_we              write z back (0 for CMP)
//  z, z_hi           result / product high word; LMULT low word
//  flag_we           {ov,cy,s,zf} update mask; masked flags read 0
//  ov, cy, s, zf     result flags
module gsu_alu_seq
  import gsu_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [IMM_W-1:0] imm,
  input  logic             y_src_sel,
  input  logic             cy_in,
  output logic             busy,
  output logic             done,
  output logic             z_we,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_hi,
  output logic [3:0]       flag_we,
  output logic             ov,
  output logic             cy,
  output logic             s,
  output logic             zf
);

  localparam int unsigned HALF = WIDTH / 2;

  alu_state_e state_q, state_d;
  logic [3:0] op_q, op_d;

  logic             done_q, done_d;
  logic             z_we_q, z_we_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] z_hi_q, z_hi_d;
  logic [3:0]       fwe_q, fwe_d;
  logic             ov_q, ov_d;
  logic             cy_q, cy_d;
  logic             s_q, s_d;
  logic             zf_q, zf_d;

  logic [WIDTH-1:0]   yv;
  logic [WIDTH-1:0]   y_op;
  logic               sub_op;
  logic               cin;
  logic [WIDTH:0]     addsub;
  logic               ov_add;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;

  assign yv     = y_src_sel ? {{(WIDTH - IMM_W){1'b0}}, imm} : y;
  assign accept = start && (state_q == ST_IDLE);
  assign mul_start = accept && is_mul(op);

  // Subtraction is x + ~Y + cin; carry-out then means "no borrow".
  always_comb begin
    sub_op = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    y_op   = sub_op ? ~yv : yv;
    case (op)
      OP_ADC, OP_SBC: cin = cy_in;
      OP_SUB, OP_CMP: cin = 1'b1;
      default:        cin = 1'b0;
    endcase
    addsub = {1'b0, x} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
    ov_add = (x[WIDTH-1] == y_op[WIDTH-1]) && (addsub[WIDTH-1] != x[WIDTH-1]);
  end

  gsu_alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .full_i   ((op == OP_FMULT) || (op == OP_LMULT)),
    .signed_i (op != OP_UMULT),
    .a_i      (x),
    .b_i      (yv),
    .done_o   (mul_done),
    .prod_o   (prod)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    done_d  = 1'b0;
    z_we_d  = 1'b0;
    z_d     = '0;
    z_hi_d  = '0;
    fwe_d   = '0;
    ov_d    = 1'b0;
    cy_d    = 1'b0;
    if (mul_done) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      z_we_d  = 1'b1;
      if ((op_q == OP_FMULT) || (op_q == OP_LMULT)) begin
        z_d   = prod[2*WIDTH-1:WIDTH];
        cy_d  = prod[WIDTH-1];
        fwe_d = FWE_LMUL;
        if (op_q == OP_LMULT) begin
          z_hi_d = prod[WIDTH-1:0];
        end
      end else begin
        z_d   = prod[WIDTH-1:0];
        fwe_d = FWE_MUL;
      end
    end else if (accept) begin
      if (is_mul(op)) begin
        state_d = ST_MUL;
        op_d    = op;
      end else begin
        done_d = 1'b1;
        z_we_d = (op != OP_CMP);
        case (op)
          OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
            z_d   = addsub[WIDTH-1:0];
            cy_d  = addsub[WIDTH];
            ov_d  = ov_add;
            fwe_d = FWE_ARITH;
          end
          OP_AND: begin z_d = x & yv;  fwe_d = FWE_LOGIC; end
          OP_OR:  begin z_d = x | yv;  fwe_d = FWE_LOGIC; end
          OP_XOR: begin z_d = x ^ yv;  fwe_d = FWE_LOGIC; end
          OP_BIC: begin z_d = x & ~yv; fwe_d = FWE_LOGIC; end
          OP_ROR: begin
            z_d   = {cy_in, x[WIDTH-1:1]};
            cy_d  = x[0];
            fwe_d = FWE_SHIFT;
          end
          OP_LSR: begin
            z_d   = {1'b0, x[WIDTH-1:1]};
            cy_d  = x[0];
            fwe_d = FWE_SHIFT;
          end
          OP_SWAP: begin
            z_d   = {x[HALF-1:0], x[WIDTH-1:HALF]};
            fwe_d = FWE_LOGIC;
          end
          default: begin
            z_d = '0;
          end
        endcase
      end
    end
    s_d  = z_d[WIDTH-1] & fwe_d[1];
    zf_d = (z_d == '0) & fwe_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      done_q  <= 1'b0;
      z_we_q  <= 1'b0;
      z_q     <= '0;
      z_hi_q  <= '0;
      fwe_q   <= '0;
      ov_q    <= 1'b0;
      cy_q    <= 1'b0;
      s_q     <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      done_q  <= done_d;
      z_we_q  <= z_we_d;
      z_q     <= z_d;
      z_hi_q  <= z_hi_d;
      fwe_q   <= fwe_d;
      ov_q    <= ov_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      zf_q    <= zf_d;
    end
  end

  assign busy    = (state_q == ST_MUL);
  assign done    = done_q;
  assign z_we    = z_we_q;
  assign z       = z_q;
  assign z_hi    = z_hi_q;
  assign flag_we = fwe_q;
  assign ov      = ov_q;
  assign cy      = cy_q;
  assign s       = s_q;
  assign zf      = zf_q;

endmodule

// File: tb/tb_gsu_alu_seq.sv
// Scoreboard bench for gsu_alu_seq (WIDTH=16, IMM_W=8).
module tb_gsu_alu_seq;
  import gsu_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] x, y;
  logic [7:0]  imm;
  logic        y_src_sel, cy_in;
  logic        busy, done, z_we;
  logic [15:0] z, z_hi;
  logic [3:0]  flag_we;
  logic        ov, cy, s, zf;

  int unsigned edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          id;
    logic [15:0] z;
    logic [15:0] zh;
    logic        zwe;
    logic [3:0]  fwe;
    logic        ov, cy, s, zf;
    int unsigned lat;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  gsu_alu_seq #(.WIDTH(16), .IMM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y), .imm(imm),
    .y_src_sel(y_src_sel), .cy_in(cy_in), .busy(busy), .done(done),
    .z_we(z_we), .z(z), .z_hi(z_hi), .flag_we(flag_we),
    .ov(ov), .cy(cy), .s(s), .zf(zf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [15:0] ez, input logic [15:0] ezh,
                              input logic ezwe, input logic [3:0] efwe, input logic eov,
                              input logic ecy, input logic es, input logic ezf,
                              input int unsigned lat);
    exp_t e;
    e.id = id; e.z = ez; e.zh = ezh; e.zwe = ezwe; e.fwe = efwe;
    e.ov = eov; e.cy = ecy; e.s = es; e.zf = ezf; e.lat = lat; e.due = 0;
    return e;
  endfunction

  // Called one time unit after a rising edge; leaves start low one time unit
  // after the next rising edge, so consecutive calls give back-to-back starts.
  task automatic issue(input logic [3:0] o, input logic [15:0] xv, input logic [15:0] yv,
                       input logic [7:0] iv, input logic sel, input logic ci,
                       input bit track, input exp_t e);
    op = o; x = xv; y = yv; imm = iv; y_src_sel = sel; cy_in = ci; start = 1'b1;
    if (track) begin
      e.due = edge_cnt + e.lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("v%0d.z", mon_e.id), 32'(z), 32'(mon_e.z));
        chk($sformatf("v%0d.z_hi", mon_e.id), 32'(z_hi), 32'(mon_e.zh));
        chk($sformatf("v%0d.z_we", mon_e.id), 32'(z_we), 32'(mon_e.zwe));
        chk($sformatf("v%0d.flag_we", mon_e.id), 32'(flag_we), 32'(mon_e.fwe));
        chk($sformatf("v%0d.flags", mon_e.id), 32'({ov, cy, s, zf}),
            32'({mon_e.ov, mon_e.cy, mon_e.s, mon_e.zf}));
        chk($sformatf("v%0d.latency_edge", mon_e.id), 32'(edge_cnt), 32'(mon_e.due));
        chk($sformatf("v%0d.busy_at_done", mon_e.id), 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t none;
    none = mk(0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1; start = 1'b0; op = '0; x = '0; y = '0; imm = '0;
    y_src_sel = 1'b0; cy_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.z_we", 32'(z_we), 32'd0);
    chk("rst.z", 32'(z), 32'd0);
    chk("rst.z_hi", 32'(z_hi), 32'd0);
    chk("rst.flag_we", 32'(flag_we), 32'd0);
    chk("rst.flags", 32'({ov, cy, s, zf}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-cycle ops, one start per cycle.
    issue(OP_ADD,  16'h7FFF, 16'h0001, 8'h00, 1'b0, 1'b0, 1, mk(1,  16'h8000, 16'h0, 1, 4'hF, 1, 0, 1, 0, 1));
    issue(OP_SUB,  16'h0000, 16'h0001, 8'h00, 1'b0, 1'b0, 1, mk(2,  16'hFFFF, 16'h0, 1, 4'hF, 0, 0, 1, 0, 1));
    issue(OP_CMP,  16'h0005, 16'h1234, 8'h05, 1'b1, 1'b0, 1, mk(3,  16'h0000, 16'h0, 0, 4'hF, 0, 1, 0, 1, 1));
    issue(OP_ROR,  16'h0001, 16'h0000, 8'h00, 1'b0, 1'b1, 1, mk(4,  16'h8000, 16'h0, 1, 4'h7, 0, 1, 1, 0, 1));
    issue(OP_SWAP, 16'h12AB, 16'h0000, 8'h00, 1'b0, 1'b0, 1, mk(5,  16'hAB12, 16'h0, 1, 4'h3, 0, 0, 1, 0, 1));
    issue(OP_ADC,  16'hFFFF, 16'h0000, 8'h00, 1'b0, 1'b1, 1, mk(6,  16'h0000, 16'h0, 1, 4'hF, 0, 1, 0, 1, 1));
    issue(OP_SBC,  16'h8000, 16'h0001, 8'h00, 1'b0, 1'b1, 1, mk(7,  16'h7FFF, 16'h0, 1, 4'hF, 1, 1, 0, 0, 1));
    issue(OP_LSR,  16'h8001, 16'h0000, 8'h00, 1'b0, 1'b1, 1, mk(8,  16'h4000, 16'h0, 1, 4'h7, 0, 1, 0, 0, 1));
    issue(OP_BIC,  16'hFF0F, 16'h00FF, 8'h00, 1'b0, 1'b0, 1, mk(9,  16'hFF00, 16'h0, 1, 4'h3, 0, 0, 1, 0, 1));
    issue(OP_XOR,  16'hAAAA, 16'hAAAA, 8'h00, 1'b0, 1'b0, 1, mk(10, 16'h0000, 16'h0, 1, 4'h3, 0, 0, 0, 1, 1));
    issue(OP_OR,   16'h0F00, 16'hFFFF, 8'hF0, 1'b1, 1'b0, 1, mk(11, 16'h0FF0, 16'h0, 1, 4'h3, 0, 0, 0, 0, 1));
    issue(OP_AND,  16'hF0F0, 16'h3C3C, 8'h00, 1'b0, 1'b0, 1, mk(12, 16'h3030, 16'h0, 1, 4'h3, 0, 0, 0, 0, 1));
    drain();

    // Half-width multiplies.
    issue(OP_MULT,  16'h00FF, 16'h0002, 8'h00, 1'b0, 1'b0, 1, mk(13, 16'hFFFE, 16'h0, 1, 4'h3, 0, 0, 1, 0, 9));
    chk("mult.busy", 32'(busy), 32'd1);
    drain();
    issue(OP_UMULT, 16'h00FF, 16'h0002, 8'h00, 1'b0, 1'b0, 1, mk(14, 16'h01FE, 16'h0, 1, 4'h3, 0, 0, 0, 0, 9));
    drain();
    issue(OP_MULT,  16'h0080, 16'h0080, 8'h00, 1'b0, 1'b0, 1, mk(15, 16'h4000, 16'h0, 1, 4'h3, 0, 0, 0, 0, 9));
    drain();

    // FMULT with an ignored start mid-run, then a start in its done cycle.
    issue(OP_FMULT, 16'h4000, 16'h4000, 8'h00, 1'b0, 1'b0, 1, mk(16, 16'h1000, 16'h0, 1, 4'h7, 0, 0, 0, 0, 17));
    repeat (3) begin @(posedge clk); #1; end
    chk("fmult.busy_mid", 32'(busy), 32'd1);
    issue(OP_ADD, 16'h1111, 16'h2222, 8'h00, 1'b0, 1'b0, 0, none);
    repeat (12) begin @(posedge clk); #1; end
    issue(OP_ADD, 16'h0001, 16'h0001, 8'h00, 1'b0, 1'b0, 1, mk(17, 16'h0002, 16'h0, 1, 4'hF, 0, 0, 0, 0, 1));
    drain();

    issue(OP_LMULT, 16'hFFFF, 16'hFFFF, 8'h00, 1'b0, 1'b0, 1, mk(18, 16'h0000, 16'h0001, 1, 4'h7, 0, 0, 0, 1, 17));
    drain();
    issue(OP_FMULT, 16'h8000, 16'h0001, 8'h00, 1'b0, 1'b0, 1, mk(19, 16'hFFFF, 16'h0, 1, 4'h7, 0, 1, 1, 0, 17));
    drain();
    issue(OP_LMULT, 16'h8000, 16'h8000, 8'h00, 1'b0, 1'b0, 1, mk(20, 16'h4000, 16'h0000, 1, 4'h7, 0, 0, 0, 0, 17));
    drain();

    // Reset in cycle 5 of a MULT: outputs clear, no done ever follows.
    issue(OP_MULT, 16'h00FF, 16'h0002, 8'h00, 1'b0, 1'b0, 0, none);
    repeat (4) begin @(posedge clk); #1; end
    chk("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.z", 32'(z), 32'd0);
    chk("abort.flag_we", 32'(flag_we), 32'd0);
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    issue(OP_ADD, 16'h0003, 16'h0004, 8'h00, 1'b0, 1'b0, 1, mk(21, 16'h0007, 16'h0, 1, 4'hF, 0, 0, 0, 0, 1));
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
